div_iter: RTL and testbench
===========================

// Module: div_iter
// PURPOSE
//  Multi-cycle radix-2 restoring divider; responder side of the EX-stage divide handshake (start_i / ready_o).
//  EX raises start_i with operands for DIV/DIVU and stalls until ready_o; this block returns {remainder, quotient}.
//  The result goes to HI (remainder) and LO (quotient). One divide in flight; no internal queue.
// PARAMETERS
//  DATA_WD  32  operand width; the counter width is $clog2(DATA_WD)
// PORTS
//  clk           in   1           rising-edge clock
//  rst           in   1           asynchronous, active-high reset
//  signed_div_i  in   1           1 = signed (DIV), 0 = unsigned (DIVU)
//  opdata1_i     in   DATA_WD     dividend
//  opdata2_i     in   DATA_WD     divisor
//  start_i       in   1           request; held high by EX until it samples ready_o=1
//  annul_i       in   1           abort the current operation
//  result_o      out  2*DATA_WD   {remainder, quotient}; valid only while ready_o=1
//  ready_o       out  1           result valid
// BEHAVIOUR
//  - One clock; reset is asynchronous and active-high. rst clears state to IDLE, ready_o=0, result_o=0, counter=0, even mid-operation.
//  - States: IDLE, DIVZERO, ON, END. All outputs are registered.
//  - IDLE, start_i=1, annul_i=0: latch operands and the sign flag.
//    - Divisor == 0 -> DIVZERO.
//    - Otherwise -> ON with cnt=0.
//    - start_i and annul_i both high -> stay IDLE.
//  - Signed mode: latch |opdata1| and |opdata2|. Record neg_q = sign1^sign2 and neg_r = sign1.
//  - ON: each edge does one shift-subtract step on the (2*DATA_WD+1)-bit partial remainder, then cnt++.
//    - On the step with cnt == DATA_WD-1: apply the sign fixups, result_o <= {rem, quo}, ready_o <= 1, go to END.
//    - ready_o therefore rises on the (DATA_WD+1)-th edge counted from the capture edge (33 for 32-bit).
//  - Sign fixups: quotient is two's-complement negated if neg_q. Remainder is negated if neg_r, so the remainder takes the sign of the dividend.
//  - Overflow 0x8000_0000 / -1 (signed) wraps: quotient 0x8000_0000, remainder 0.
//  - DIVZERO: the next edge sets result_o=0, ready_o=1 and goes to END.
//  - END: ready_o and result_o are held while start_i=1. When start_i=0: IDLE, ready_o<=0, result_o<=0.
//  - annul_i=1 in DIVZERO, ON or END: the next edge goes to IDLE, ready_o=0, result_o=0, no result is delivered.
//  - Operand changes after the capture edge are ignored until the block returns to IDLE.
//  - Back-to-back requests: a new request is accepted only from IDLE. start_i must drop for at least one cycle.
// CONFIGURATION
//  DIV_EARLY_OUT_EN
//  - Defined: in IDLE, if |dividend| < |divisor| and divisor != 0, go straight to END on the capture edge.
//    - result_o = {opdata1_i, 0}: the remainder is the original signed dividend.
//    - ready_o is high after the 1st edge.
//  - Undefined: every nonzero divisor takes the full DATA_WD-step path. Results are identical; only latency differs.
// TESTING
//  - DIVU 7/2, start held -> ready_o on edge 33, result_o = {32'h1, 32'h3}. After start drops: IDLE, ready 0, result 0.
//  - DIV -7/2 (0xFFFF_FFF9 / 2) -> {32'hFFFF_FFFF, 32'hFFFF_FFFD}.
//  - DIV 0x8000_0000 / 0xFFFF_FFFF -> {32'h0, 32'h8000_0000}.
//  - DIV 5/0 -> ready_o on edge 2, result_o = 64'h0.
//  - Start DIVU 100/3, assert annul_i on edge 10 -> IDLE, ready_o never rises.
//    A later 100/3 -> {32'h1, 32'd33}.
//  - Start DIVU 0xFFFF_FFFF/1, assert rst mid-ON -> outputs 0 immediately (async). The next divide is correct.
//    With DIV_EARLY_OUT_EN: DIVU 3/10 -> ready_o after edge 1, result_o = {32'h3, 32'h0}.

Source files
------------

// File: rtl/div_iter.sv
// Multi-cycle radix-2 restoring divider returning {remainder, quotient} over a start/ready handshake.
// Optional macro DIV_EARLY_OUT_EN: finish on the capture edge when |dividend| < |divisor|.
module div_iter #(
  parameter int DATA_WD = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   signed_div_i,
  input  logic [DATA_WD-1:0]     opdata1_i,
  input  logic [DATA_WD-1:0]     opdata2_i,
  input  logic                   start_i,
  input  logic                   annul_i,
  output logic [2*DATA_WD-1:0]   result_o,
  output logic                   ready_o
);

  localparam int CNT_W = $clog2(DATA_WD);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WD - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DIVZERO,
    S_ON,
    S_END
  } state_t;

  state_t                 state_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [2*DATA_WD-1:0]   part_q;
  logic [DATA_WD-1:0]     divisor_q;
  logic                   neg_quo_q;
  logic                   neg_rem_q;
  logic [2*DATA_WD-1:0]   result_q;
  logic                   ready_q;

  // Magnitude of an operand; the most negative value maps onto itself, which is
  // the correct unsigned magnitude.
  function automatic logic [DATA_WD-1:0] mag(input logic sgn, input logic [DATA_WD-1:0] v);
    return (sgn && v[DATA_WD-1]) ? -v : v;
  endfunction

  function automatic logic [DATA_WD-1:0] fix_sign(input logic neg, input logic [DATA_WD-1:0] v);
    return neg ? -v : v;
  endfunction

  logic [DATA_WD-1:0]   a_mag;
  logic [DATA_WD-1:0]   b_mag;
  logic                 cap_neg_quo;
  logic                 cap_neg_rem;
  logic [DATA_WD:0]     rem_sh;
  logic                 ge;
  logic [DATA_WD-1:0]   rem_new;
  logic [2*DATA_WD-1:0] step_d;
  logic [DATA_WD-1:0]   quo_fin;
  logic [DATA_WD-1:0]   rem_fin;

  always_comb begin
    a_mag       = mag(signed_div_i, opdata1_i);
    b_mag       = mag(signed_div_i, opdata2_i);
    cap_neg_quo = signed_div_i & (opdata1_i[DATA_WD-1] ^ opdata2_i[DATA_WD-1]);
    cap_neg_rem = signed_div_i & opdata1_i[DATA_WD-1];

    // part_q holds {remainder, dividend/quotient bits}; shifting it left by one forms
    // the (2*DATA_WD+1)-bit working value whose top DATA_WD+1 bits are compared.
    rem_sh  = part_q[2*DATA_WD-1:DATA_WD-1];
    ge      = (rem_sh >= {1'b0, divisor_q});
    rem_new = ge ? (rem_sh[DATA_WD-1:0] - divisor_q) : rem_sh[DATA_WD-1:0];
    step_d  = {rem_new, part_q[DATA_WD-2:0], ge};

    quo_fin = fix_sign(neg_quo_q, step_d[DATA_WD-1:0]);
    rem_fin = fix_sign(neg_rem_q, step_d[2*DATA_WD-1:DATA_WD]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      part_q    <= '0;
      divisor_q <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      result_q  <= '0;
      ready_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_i && !annul_i) begin
            divisor_q <= b_mag;
            part_q    <= {{DATA_WD{1'b0}}, a_mag};
            neg_quo_q <= cap_neg_quo;
            neg_rem_q <= cap_neg_rem;
            cnt_q     <= '0;
            if (opdata2_i == '0) begin
              state_q <= S_DIVZERO;
            end
`ifdef DIV_EARLY_OUT_EN
            else if (a_mag < b_mag) begin
              state_q  <= S_END;
              result_q <= {opdata1_i, {DATA_WD{1'b0}}};
              ready_q  <= 1'b1;
            end
`endif
            else begin
              state_q <= S_ON;
            end
          end
        end

        S_DIVZERO: begin
          if (annul_i) begin
            state_q  <= S_IDLE;
            result_q <= '0;
            ready_q  <= 1'b0;
          end else begin
            state_q  <= S_END;
            result_q <= '0;
            ready_q  <= 1'b1;
          end
        end

        S_ON: begin
          if (annul_i) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            result_q <= '0;
            ready_q  <= 1'b0;
          end else begin
            part_q <= step_d;
            cnt_q  <= cnt_q + CNT_ONE;
            if (cnt_q == CNT_LAST) begin
              state_q  <= S_END;
              result_q <= {rem_fin, quo_fin};
              ready_q  <= 1'b1;
            end
          end
        end

        S_END: begin
          // The result stays up until EX releases start_i.
          if (annul_i || !start_i) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            result_q <= '0;
            ready_q  <= 1'b0;
          end
        end

        default: begin
          state_q  <= S_IDLE;
          result_q <= '0;
          ready_q  <= 1'b0;
        end
      endcase
    end
  end

  assign result_o = result_q;
  assign ready_o  = ready_q;

endmodule

// File: tb/tb_div_iter.sv
// Randomized self-checking bench for div_iter against an arithmetic reference model.
module tb_div_iter;

  localparam int W = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic            signed_div_i;
  logic [W-1:0]    opdata1_i;
  logic [W-1:0]    opdata2_i;
  logic            start_i;
  logic            annul_i;
  logic [2*W-1:0]  result_o;
  logic            ready_o;

  int n_pass  = 0;
  int n_total = 0;

  div_iter #(.DATA_WD(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
    .ready_o      (ready_o)
  );

  always #5 clk = ~clk;

  // Reference: truncating division in 64-bit arithmetic, {remainder, quotient}.
  function automatic logic [2*W-1:0] model(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b);
    longint sa, sb, q, r;
    if (b == '0) return '0;
    if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'b0, a});
      sb = longint'({32'b0, b});
    end
    q = sa / sb;
    r = sa % sb;
    return {r[W-1:0], q[W-1:0]};
  endfunction

  function automatic int exp_lat(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef DIV_EARLY_OUT_EN
    longint ma, mb;
`endif
    if (b == '0) return 2;
`ifdef DIV_EARLY_OUT_EN
    ma = sgn ? longint'($signed(a)) : longint'({32'b0, a});
    mb = sgn ? longint'($signed(b)) : longint'({32'b0, b});
    if (ma < 0) ma = -ma;
    if (mb < 0) mb = -mb;
    if (ma < mb) return 1;
`else
    if (sgn) return W + 1;
`endif
    return W + 1;
  endfunction

  // Runs one request: latency counted in edges from the capture edge, then one held
  // cycle with start high, then start drops for one edge.
  task automatic do_div(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                        output logic [2*W-1:0] res, output int lat,
                        output logic held_ok, output logic idle_ok);
    signed_div_i = sgn;
    opdata1_i    = a;
    opdata2_i    = b;
    start_i      = 1'b1;
    lat          = 0;
    do begin
      @(posedge clk); #1;
      lat++;
      if (lat == 1) begin
        opdata1_i    = $urandom;
        opdata2_i    = $urandom;
        signed_div_i = 1'($urandom_range(0, 1));
      end
    end while (!ready_o && lat < 100);
    res = result_o;
    @(posedge clk); #1;
    held_ok = (ready_o === 1'b1) && (result_o === res);
    start_i = 1'b0;
    @(posedge clk); #1;
    idle_ok = (ready_o === 1'b0) && (result_o === '0);
  endtask

  task automatic test_reset();
    rst = 1'b1; start_i = 1'b1; annul_i = 1'b0; signed_div_i = 1'b0;
    opdata1_i = 32'd7; opdata2_i = 32'd2;
    repeat (3) @(posedge clk);
    #1;
    n_total++; if (ready_o !== 1'b0) $display("FAIL reset_ready got %b exp 0", ready_o); else n_pass++;
    n_total++; if (result_o !== '0) $display("FAIL reset_result got %h exp 0", result_o); else n_pass++;
    start_i = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_divu_basic();
    logic [2*W-1:0] res; int lat; logic h, i;
    do_div(1'b0, 32'd7, 32'd2, res, lat, h, i);
    n_total++; if (res !== {32'h1, 32'h3}) $display("FAIL divu_7_2 got %h exp %h", res, {32'h1, 32'h3}); else n_pass++;
    n_total++; if (lat !== 33) $display("FAIL divu_7_2_latency got %0d exp 33", lat); else n_pass++;
    n_total++; if (h !== 1'b1) $display("FAIL divu_7_2_hold got %b exp 1", h); else n_pass++;
    n_total++; if (i !== 1'b1) $display("FAIL divu_7_2_idle got %b exp 1", i); else n_pass++;
  endtask

  task automatic test_signed();
    logic [2*W-1:0] res; int lat; logic h, i;
    do_div(1'b1, 32'hFFFF_FFF9, 32'd2, res, lat, h, i);
    n_total++; if (res !== {32'hFFFF_FFFF, 32'hFFFF_FFFD}) $display("FAIL div_m7_2 got %h exp %h", res, {32'hFFFF_FFFF, 32'hFFFF_FFFD}); else n_pass++;
    n_total++; if (lat !== 33) $display("FAIL div_m7_2_latency got %0d exp 33", lat); else n_pass++;
    do_div(1'b1, 32'd7, 32'hFFFF_FFFE, res, lat, h, i);
    n_total++; if (res !== {32'h1, 32'hFFFF_FFFD}) $display("FAIL div_7_m2 got %h exp %h", res, {32'h1, 32'hFFFF_FFFD}); else n_pass++;
    do_div(1'b1, 32'hFFFF_FFF9, 32'hFFFF_FFFE, res, lat, h, i);
    n_total++; if (res !== {32'hFFFF_FFFF, 32'h3}) $display("FAIL div_m7_m2 got %h exp %h", res, {32'hFFFF_FFFF, 32'h3}); else n_pass++;
  endtask

  task automatic test_overflow();
    logic [2*W-1:0] res; int lat; logic h, i;
    do_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, res, lat, h, i);
    n_total++; if (res !== {32'h0, 32'h8000_0000}) $display("FAIL div_overflow got %h exp %h", res, {32'h0, 32'h8000_0000}); else n_pass++;
    n_total++; if (lat !== 33) $display("FAIL div_overflow_latency got %0d exp 33", lat); else n_pass++;
  endtask

  task automatic test_divzero();
    logic [2*W-1:0] res; int lat; logic h, i;
    do_div(1'b1, 32'd5, 32'd0, res, lat, h, i);
    n_total++; if (res !== '0) $display("FAIL divzero got %h exp 0", res); else n_pass++;
    n_total++; if (lat !== 2) $display("FAIL divzero_latency got %0d exp 2", lat); else n_pass++;
    n_total++; if (h !== 1'b1) $display("FAIL divzero_hold got %b exp 1", h); else n_pass++;
    n_total++; if (i !== 1'b1) $display("FAIL divzero_idle got %b exp 1", i); else n_pass++;
  endtask

  task automatic test_annul();
    logic [2*W-1:0] res; int lat, highs; logic h, i;
    // Annul during ON, on edge 10.
    signed_div_i = 1'b0; opdata1_i = 32'd100; opdata2_i = 32'd3; start_i = 1'b1;
    highs = 0;
    for (int e = 1; e <= 9; e++) begin
      @(posedge clk); #1;
      if (ready_o) highs++;
    end
    annul_i = 1'b1;
    @(posedge clk); #1;
    n_total++; if (ready_o !== 1'b0 || result_o !== '0) $display("FAIL annul_on got %b/%h exp 0/0", ready_o, result_o); else n_pass++;
    annul_i = 1'b0; start_i = 1'b0;
    for (int e = 0; e < 40; e++) begin
      @(posedge clk); #1;
      if (ready_o) highs++;
    end
    n_total++; if (highs !== 0) $display("FAIL annul_no_result got %0d ready cycles exp 0", highs); else n_pass++;
    do_div(1'b0, 32'd100, 32'd3, res, lat, h, i);
    n_total++; if (res !== {32'h1, 32'd33}) $display("FAIL after_annul got %h exp %h", res, {32'h1, 32'd33}); else n_pass++;
    // start and annul together in IDLE: nothing is accepted.
    start_i = 1'b1; annul_i = 1'b1; highs = 0;
    for (int e = 0; e < 40; e++) begin
      @(posedge clk); #1;
      if (ready_o) highs++;
    end
    n_total++; if (highs !== 0) $display("FAIL start_annul_idle got %0d ready cycles exp 0", highs); else n_pass++;
    start_i = 1'b0; annul_i = 1'b0;
    @(posedge clk); #1;
    // Annul while the result is held.
    opdata1_i = 32'd7; opdata2_i = 32'd2; start_i = 1'b1; lat = 0;
    do begin @(posedge clk); #1; lat++; end while (!ready_o && lat < 100);
    annul_i = 1'b1;
    @(posedge clk); #1;
    n_total++; if (ready_o !== 1'b0 || result_o !== '0) $display("FAIL annul_end got %b/%h exp 0/0", ready_o, result_o); else n_pass++;
    annul_i = 1'b0; start_i = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_async_reset();
    logic [2*W-1:0] res; int lat; logic h, i;
    signed_div_i = 1'b0; opdata1_i = 32'hFFFF_FFFF; opdata2_i = 32'd1; start_i = 1'b1;
    repeat (10) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    n_total++; if (ready_o !== 1'b0 || result_o !== '0) $display("FAIL rst_mid_on got %b/%h exp 0/0", ready_o, result_o); else n_pass++;
    #1 rst = 1'b0; start_i = 1'b0;
    @(posedge clk); #1;
    do_div(1'b0, 32'hFFFF_FFFF, 32'd1, res, lat, h, i);
    n_total++; if (res !== {32'h0, 32'hFFFF_FFFF}) $display("FAIL after_rst got %h exp %h", res, {32'h0, 32'hFFFF_FFFF}); else n_pass++;
    n_total++; if (lat !== 33) $display("FAIL after_rst_latency got %0d exp 33", lat); else n_pass++;
    // Reset while a result is presented must clear it without a clock edge.
    opdata1_i = 32'd9; opdata2_i = 32'd4; start_i = 1'b1; lat = 0;
    do begin @(posedge clk); #1; lat++; end while (!ready_o && lat < 100);
    n_total++; if (result_o !== {32'h1, 32'h2}) $display("FAIL pre_rst_result got %h exp %h", result_o, {32'h1, 32'h2}); else n_pass++;
    #1 rst = 1'b1;
    #1;
    n_total++; if (ready_o !== 1'b0 || result_o !== '0) $display("FAIL rst_async_end got %b/%h exp 0/0", ready_o, result_o); else n_pass++;
    #1 rst = 1'b0; start_i = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_early_out();
`ifdef DIV_EARLY_OUT_EN
    logic [2*W-1:0] res; int lat; logic h, i;
    do_div(1'b0, 32'd3, 32'd10, res, lat, h, i);
    n_total++; if (res !== {32'h3, 32'h0}) $display("FAIL early_out got %h exp %h", res, {32'h3, 32'h0}); else n_pass++;
    n_total++; if (lat !== 1) $display("FAIL early_out_latency got %0d exp 1", lat); else n_pass++;
`else
    logic [2*W-1:0] res; int lat; logic h, i;
    do_div(1'b0, 32'd3, 32'd10, res, lat, h, i);
    n_total++; if (res !== {32'h3, 32'h0}) $display("FAIL small_dividend got %h exp %h", res, {32'h3, 32'h0}); else n_pass++;
    n_total++; if (lat !== 33) $display("FAIL small_dividend_latency got %0d exp 33", lat); else n_pass++;
`endif
  endtask

  task automatic test_random();
    logic [2*W-1:0] res, exp; int lat, el; logic h, i, sgn; logic [W-1:0] a, b;
    for (int k = 0; k < 40; k++) begin
      sgn = 1'($urandom_range(0, 1));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 4))
        0: b = 32'($urandom_range(1, 15));
        1: a = 32'($urandom_range(0, 15));
        2: b = 32'hFFFF_FFFF;
        3: b = (k % 8 == 3) ? 32'd0 : b;
        default: ;
      endcase
      exp = model(sgn, a, b);
      el  = exp_lat(sgn, a, b);
      do_div(sgn, a, b, res, lat, h, i);
      n_total++; if (res !== exp) $display("FAIL rand_%0d s=%b %h/%h got %h exp %h", k, sgn, a, b, res, exp); else n_pass++;
      n_total++; if (lat !== el) $display("FAIL rand_%0d_latency got %0d exp %0d", k, lat, el); else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    logic [2*W-1:0] res; int lat; logic h, i;
    logic [W-1:0] a [3] = '{32'd1000, 32'hFFFF_FC18, 32'd12345};
    logic [W-1:0] b [3] = '{32'd7, 32'd7, 32'hFFFF_FFF6};
    for (int k = 0; k < 3; k++) begin
      do_div(1'b1, a[k], b[k], res, lat, h, i);
      n_total++; if (res !== model(1'b1, a[k], b[k])) $display("FAIL b2b_%0d got %h exp %h", k, res, model(1'b1, a[k], b[k])); else n_pass++;
      n_total++; if (i !== 1'b1) $display("FAIL b2b_%0d_idle got %b exp 1", k, i); else n_pass++;
    end
  endtask

  initial begin
    rst = 1'b1; start_i = 1'b0; annul_i = 1'b0; signed_div_i = 1'b0;
    opdata1_i = '0; opdata2_i = '0;
    test_reset();
    test_divu_basic();
    test_signed();
    test_overflow();
    test_divzero();
    test_annul();
    test_async_reset();
    test_early_out();
    test_random();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
